// File: rtl/bp_update_tracker.sv
// Branch-predictor update tracker. It records predicted conditional branches in program order,
// collects their resolutions and drains one predictor-update packet per cycle.
module bp_update_tracker #(
   parameter int VLEN  = 64,
   parameter int DEPTH = 8,
   parameter int IDW   = $clog2(DEPTH)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            debug_mode_i,
   input  logic            alloc_valid_i,
   output logic            alloc_ready_o,
   input  logic [VLEN-1:0] alloc_pc_i,
   input  logic            alloc_lbp_valid_i,
   input  logic            alloc_lbp_taken_i,
   input  logic            alloc_gbp_valid_i,
   input  logic            alloc_gbp_taken_i,
   output logic [IDW-1:0]  alloc_id_o,
   input  logic            resolve_valid_i,
   input  logic [IDW-1:0]  resolve_id_i,
   input  logic            resolve_taken_i,
   input  logic            resolve_mispredict_i,
   output logic            update_valid_o,
   output logic [VLEN-1:0] update_pc_o,
   output logic            update_taken_o,
   output logic            update_lbp_valid_o,
   output logic            update_lbp_taken_o,
   output logic            update_gbp_valid_o,
   output logic            update_gbp_taken_o,
   output logic [IDW:0]    count_o
);

   logic [DEPTH-1:0] live;
   logic [DEPTH-1:0] resolved;
   logic [DEPTH-1:0] taken;
   logic [DEPTH-1:0] lbp_v;
   logic [DEPTH-1:0] lbp_t;
   logic [DEPTH-1:0] gbp_v;
   logic [DEPTH-1:0] gbp_t;
   logic [VLEN-1:0]  pc [DEPTH];

   logic [IDW:0]     head;
   logic [IDW:0]     tail;
   logic [IDW-1:0]   head_idx;
   logic [IDW-1:0]   tail_idx;
   logic [IDW-1:0]   res_off;
   logic             full;
   logic             alloc_fire;
   logic             resolve_acc;
   logic             mispredict_acc;
   logic             drain;
   logic [DEPTH-1:0] squash_mask;
   logic [DEPTH-1:0] drain_mask;
   logic [DEPTH-1:0] alloc_mask;

   assign head_idx       = head[IDW-1:0];
   assign tail_idx       = tail[IDW-1:0];
   assign full           = (head_idx == tail_idx) && (head[IDW] != tail[IDW]);
   assign alloc_ready_o  = !full && !flush_i && !(resolve_valid_i && resolve_mispredict_i);
   assign alloc_fire     = alloc_valid_i && alloc_ready_o;
   assign alloc_id_o     = tail_idx;
   assign count_o        = tail - head;
   assign resolve_acc    = resolve_valid_i && live[resolve_id_i];
   assign mispredict_acc = resolve_acc && resolve_mispredict_i;
   assign res_off        = resolve_id_i - head_idx;
   // Drain looks only at registered state, so a same-cycle resolve of the head waits one edge.
   assign drain          = live[head_idx] && resolved[head_idx];

   // Age of each slot relative to head decides which entries a mispredict squashes.
   always_comb begin
      squash_mask = '0;
      drain_mask  = '0;
      alloc_mask  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (mispredict_acc && ((IDW'(i) - head_idx) > res_off)) begin
            squash_mask[i] = 1'b1;
         end
      end
      drain_mask[head_idx] = drain;
      alloc_mask[tail_idx] = alloc_fire;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         live               <= '0;
         head               <= '0;
         tail               <= '0;
         update_valid_o     <= 1'b0;
         update_pc_o        <= '0;
         update_taken_o     <= 1'b0;
         update_lbp_valid_o <= 1'b0;
         update_lbp_taken_o <= 1'b0;
         update_gbp_valid_o <= 1'b0;
         update_gbp_taken_o <= 1'b0;
      end else if (flush_i) begin
         live           <= '0;
         head           <= '0;
         tail           <= '0;
         update_valid_o <= 1'b0;
      end else begin
         update_valid_o <= drain && !debug_mode_i;
         if (drain) begin
            update_pc_o        <= pc[head_idx];
            update_taken_o     <= taken[head_idx];
            update_lbp_valid_o <= lbp_v[head_idx];
            update_lbp_taken_o <= lbp_t[head_idx];
            update_gbp_valid_o <= gbp_v[head_idx];
            update_gbp_taken_o <= gbp_t[head_idx];
            head               <= head + (IDW+1)'(1);
         end
         if (mispredict_acc) begin
            tail <= head + {1'b0, res_off} + (IDW+1)'(1);
         end else if (alloc_fire) begin
            tail <= tail + (IDW+1)'(1);
         end
         live <= (live & ~squash_mask & ~drain_mask) | alloc_mask;
      end
   end

   // Payload needs no reset: it is only ever read while its live bit is set.
   always_ff @(posedge clk_i) begin
      if (!flush_i && resolve_acc) begin
         resolved[resolve_id_i] <= 1'b1;
         taken[resolve_id_i]    <= resolve_taken_i;
      end
      if (alloc_fire) begin
         resolved[tail_idx] <= 1'b0;
         pc[tail_idx]       <= alloc_pc_i;
         lbp_v[tail_idx]    <= alloc_lbp_valid_i;
         lbp_t[tail_idx]    <= alloc_lbp_taken_i;
         gbp_v[tail_idx]    <= alloc_gbp_valid_i;
         gbp_t[tail_idx]    <= alloc_gbp_taken_i;
      end
   end

endmodule
